// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_fifo and fetch_unit.
package rv_fetch_pkg;

    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST =
        32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] pc_inc(
        input logic [ILEN-1:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries.
// Flush wins over push and pop.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         valid,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push)
                           - CW'(pop);
        end
    end

    assign head  = mem[rptr];
    assign valid = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage with prefetch FIFO.
// Optional counters: define FETCH_PERF_EN.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
`ifdef FETCH_PERF_EN
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_dropped,
`endif
    output logic        o_f_valid,
    output logic [31:0] o_f_pc,
    output logic [31:0] o_f_inst
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;

    logic         run;
    logic         credit;
    logic         req;
    logic         acc;
    logic         rsp;
    logic         drop_now;
    logic         push;
    logic         pop;
    logic         f_valid;
    fetch_entry_t head;
    fetch_entry_t wdata;
    logic [31:0]  redir_pc;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^i_redirect_pc[1:0];

    assign redir_pc = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Buffered plus in-flight words never exceed FIFO_DEPTH,
    // so a returning word always has a free slot.
    assign inflight = {1'b0, count}
                    + {1'b0, outstanding};
    assign credit   = inflight
                    < (CW+1)'(FIFO_DEPTH);

    assign run      = (state == RUN);
    assign req      = run && !i_redirect && credit;
    assign acc      = req && i_imem_gnt;
    assign rsp      = run && i_imem_rvalid;
    assign drop_now = rsp
                   && (i_redirect || drop_cnt != '0);
    assign push     = rsp && !drop_now;
    assign pop      = f_valid && !i_stall
                   && !i_redirect;

    assign wdata.pc   = resp_pc;
    assign wdata.inst = i_imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding + CW'(acc)
                                       - CW'(rsp);
            unique case (1'b1)
                i_redirect: fetch_pc <= redir_pc;
                acc:        fetch_pc <= pc_inc(fetch_pc);
                default:    fetch_pc <= fetch_pc;
            endcase
            if (i_redirect) begin
                resp_pc <= redir_pc;
            end else if (push) begin
                resp_pc <= pc_inc(resp_pc);
            end
            // Everything still in flight at a redirect
            // belongs to the old path.
            if (i_redirect) begin
                drop_cnt <= outstanding - CW'(rsp);
            end else if (rsp && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .flush (i_redirect),
        .head  (head),
        .valid (f_valid),
        .count (count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_fetched <= '0;
            o_perf_dropped <= '0;
        end else begin
            o_perf_fetched <= o_perf_fetched
                            + 32'(push);
            o_perf_dropped <= o_perf_dropped
                + 32'(drop_now)
                + (i_redirect ? 32'(count) : 32'd0);
        end
    end
`endif

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc;
    assign o_f_valid   = f_valid;
    assign o_f_pc      = f_valid ? head.pc : 32'h0;
    assign o_f_inst    = f_valid ? head.inst
                                 : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order
// memory model answering one cycle after grant.
module tb_fetch_unit;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_f_valid;
    logic [31:0] o_f_pc;
    logic [31:0] o_f_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] o_perf_fetched;
    logic [31:0] o_perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
`ifdef FETCH_PERF_EN
        .o_perf_fetched(o_perf_fetched),
        .o_perf_dropped(o_perf_dropped),
`endif
        .o_f_valid     (o_f_valid),
        .o_f_pc        (o_f_pc),
        .o_f_inst      (o_f_inst)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] pend [$];
    bit          auto_rsp;
    bit          acc_s;
    bit          rsp_s;
    logic [31:0] addr_s;

    function automatic logic [31:0] mem_word(
        input logic [31:0] a
    );
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%h exp=%h",
                    tag, obs, exp);
    endtask

    task automatic tick();
        #1;
        acc_s  = (o_imem_req === 1'b1)
              && (i_imem_gnt === 1'b1);
        rsp_s  = (i_imem_rvalid === 1'b1);
        addr_s = o_imem_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp_s && pend.size() > 0)
                void'(pend.pop_front());
            if (acc_s)
                pend.push_back(addr_s);
        end
        i_imem_rvalid = auto_rsp && !rst
                     && (pend.size() > 0);
        i_imem_rdata  = (pend.size() > 0)
                      ? mem_word(pend[0]) : 32'h0;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_imem_gnt    = 1'b1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        auto_rsp      = 1'b1;

        tick();
        tick();
        chk("rst_req",   o_imem_req,  0);
        chk("rst_addr",  o_imem_addr, 32'h100);
        chk("rst_valid", o_f_valid,   0);
        chk("rst_pc",    o_f_pc,      32'h0);
        chk("rst_inst",  o_f_inst,    NOP_INST);
`ifdef FETCH_PERF_EN
        chk("rst_pf_f", o_perf_fetched, 0);
        chk("rst_pf_d", o_perf_dropped, 0);
`endif

        rst = 1'b0;
        tick();
        chk("run_req",   o_imem_req,  1);
        chk("addr0",     o_imem_addr, 32'h100);
        tick();
        chk("addr1",     o_imem_addr, 32'h104);
        chk("lat_valid", o_f_valid,   0);
        tick();
        chk("head0_v",   o_f_valid,   1);
        chk("head0_pc",  o_f_pc,      32'h100);
        chk("head0_in",  o_f_inst,    32'hDEAD_0100);
        chk("addr2",     o_imem_addr, 32'h108);
        chk("credit0",   o_imem_req,  0);
        tick();
        chk("head1_pc",  o_f_pc,      32'h104);
        chk("head1_in",  o_f_inst,    32'hDEAD_0104);
        chk("req_again", o_imem_req,  1);

        i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", o_f_pc, 32'h104);
        end
        chk("stall_cred", o_imem_req, 0);
        i_stall = 1'b0;
        tick();
        chk("unst_pc",   o_f_pc,      32'h108);
        chk("unst_in",   o_f_inst,    32'hDEAD_0108);
        chk("unst_addr", o_imem_addr, 32'h10C);

        auto_rsp = 1'b0;
        tick();
        tick();
        chk("two_out",   o_imem_req,  0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h203;
        #1;
        chk("redir_req", o_imem_req,  0);
        auto_rsp = 1'b1;
        tick();
        i_redirect = 1'b0;
        tick();
        chk("drop1_v",   o_f_valid,   0);
        chk("redir_adr", o_imem_addr, 32'h200);
        tick();
        chk("drop2_v",   o_f_valid,   0);
        tick();
        chk("tgt_v",     o_f_valid,   1);
        chk("tgt_pc",    o_f_pc,      32'h200);
        chk("tgt_in",    o_f_inst,    32'hDEAD_0200);
        chk("rv_pend",   i_imem_rvalid, 1);

        i_stall       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        #1;
        chk("same_v",    o_f_valid,   0);
        chk("same_inst", o_f_inst,    NOP_INST);
        chk("same_pc",   o_f_pc,      32'h0);
        chk("top_addr",  o_imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", o_imem_addr, 32'h0);
        tick();
        chk("top_pc",    o_f_pc,      32'hFFFF_FFFC);
        chk("top_in",    o_f_inst,    32'h2152_FFFC);
        tick();
        chk("wrap_v",    o_f_valid,   1);
        chk("wrap_in",   o_f_inst,    32'hDEAD_0000);
`ifdef FETCH_PERF_EN
        chk("pf_fetch",  o_perf_fetched, 6);
        chk("pf_drop",   o_perf_dropped, 4);
`endif

        rst = 1'b1;
        tick();
        chk("mid_req",   o_imem_req,  0);
        chk("mid_addr",  o_imem_addr, 32'h100);
        chk("mid_valid", o_f_valid,   0);
        chk("mid_inst",  o_f_inst,    NOP_INST);

        $display("%0d/%0d checks passed",
                 passed, total);
        $finish;
    end

endmodule
